// File: rtl/apu_reg_file_if.sv
// CPU-side byte bus for the sound register file: write/read strobes, address,
// data and the channel-status input returned through NR52.
interface apu_reg_file_if;
   logic       wr_en;
   logic       rd_en;
   logic [7:0] addr;
   logic [7:0] wdata;
   logic [3:0] ch_on;
   logic [7:0] rdata;
   logic       rvalid;

   modport master (
      output wr_en, rd_en, addr, wdata, ch_on,
      input  rdata, rvalid
   );

   modport slave (
      input  wr_en, rd_en, addr, wdata, ch_on,
      output rdata, rvalid
   );
endinterface

// File: rtl/apu_reg_file.sv
// apu_reg_file: sound register file NR10-NR52 (0xFF10-0xFF26). Decodes CPU byte
// writes into pulse-channel and mixer control fields, issues one-cycle trigger
// and length-load strobes, and implements master power-off via NR52 bit 7.
// Optional feature macro: APU_READBACK_EN enables masked register read-back;
// without it rdata is 0x00 and rvalid is 0.
module apu_reg_file (
   input  logic                 clk,
   input  logic                 reset,
   apu_reg_file_if.slave        bus,
   output logic [2:0]           sq1_swpPd,
   output logic                 sq1_negate,
   output logic [2:0]           sq1_shift,
   output logic [1:0]           sq1_duty,
   output logic [1:0]           sq2_duty,
   output logic [5:0]           sq1_lenLoad,
   output logic [5:0]           sq2_lenLoad,
   output logic                 sq1_lenStrobe,
   output logic                 sq2_lenStrobe,
   output logic [3:0]           sq1_startVol,
   output logic [3:0]           sq2_startVol,
   output logic                 sq1_envAdd,
   output logic                 sq2_envAdd,
   output logic [2:0]           sq1_period,
   output logic [2:0]           sq2_period,
   output logic [10:0]          sq1_freq,
   output logic [10:0]          sq2_freq,
   output logic                 sq1_lenEnable,
   output logic                 sq2_lenEnable,
   output logic                 sq1_trigger,
   output logic                 sq2_trigger,
   output logic [2:0]           vol_left,
   output logic [2:0]           vol_right,
   output logic [7:0]           pan,
   output logic                 power
);

   localparam int unsigned FREQ_W = 11;

   localparam logic [7:0] A_NR10 = 8'h10;
   localparam logic [7:0] A_NR11 = 8'h11;
   localparam logic [7:0] A_NR12 = 8'h12;
   localparam logic [7:0] A_NR13 = 8'h13;
   localparam logic [7:0] A_NR14 = 8'h14;
   localparam logic [7:0] A_NR21 = 8'h16;
   localparam logic [7:0] A_NR22 = 8'h17;
   localparam logic [7:0] A_NR23 = 8'h18;
   localparam logic [7:0] A_NR24 = 8'h19;
   localparam logic [7:0] A_NR50 = 8'h24;
   localparam logic [7:0] A_NR51 = 8'h25;
   localparam logic [7:0] A_NR52 = 8'h26;

   logic [6:0]        r_nr10;
   logic [7:0]        r_nr11;
   logic [7:0]        r_nr12;
   logic [FREQ_W-1:0] r_sq1_freq;
   logic              r_sq1_len_en;
   logic [7:0]        r_nr21;
   logic [7:0]        r_nr22;
   logic [FREQ_W-1:0] r_sq2_freq;
   logic              r_sq2_len_en;
   logic [2:0]        r_vol_left;
   logic [2:0]        r_vol_right;
   logic [7:0]        r_pan;
   logic              r_power;
   logic              r_sq1_trig;
   logic              r_sq2_trig;
   logic              r_sq1_len_stb;
   logic              r_sq2_len_stb;

   logic              w_pwr_off;
   logic              w_pwr_on;
   logic              w_wr_lo;

   // NR52 write decode, and the power-gated write window for 0x10-0x25
   assign w_pwr_off = bus.wr_en && (bus.addr == A_NR52) && !bus.wdata[7];
   assign w_pwr_on  = bus.wr_en && (bus.addr == A_NR52) &&  bus.wdata[7];
   assign w_wr_lo   = bus.wr_en && r_power && (bus.addr >= A_NR10) && (bus.addr <= A_NR51);

   // Register capture, power-off clear and single-cycle strobe generation
   always_ff @(posedge clk) begin
      if (reset || w_pwr_off) begin
         r_nr10        <= '0;
         r_nr11        <= '0;
         r_nr12        <= '0;
         r_sq1_freq    <= '0;
         r_sq1_len_en  <= 1'b0;
         r_nr21        <= '0;
         r_nr22        <= '0;
         r_sq2_freq    <= '0;
         r_sq2_len_en  <= 1'b0;
         r_vol_left    <= '0;
         r_vol_right   <= '0;
         r_pan         <= '0;
         r_power       <= reset;
         r_sq1_trig    <= 1'b0;
         r_sq2_trig    <= 1'b0;
         r_sq1_len_stb <= 1'b0;
         r_sq2_len_stb <= 1'b0;
      end else begin
         r_sq1_trig    <= 1'b0;
         r_sq2_trig    <= 1'b0;
         r_sq1_len_stb <= 1'b0;
         r_sq2_len_stb <= 1'b0;
         if (w_pwr_on) begin
            r_power <= 1'b1;
         end else if (w_wr_lo) begin
            case (bus.addr)
               A_NR10: r_nr10 <= bus.wdata[6:0];
               A_NR11: begin
                  r_nr11        <= bus.wdata;
                  r_sq1_len_stb <= 1'b1;
               end
               A_NR12: r_nr12 <= bus.wdata;
               A_NR13: r_sq1_freq[7:0] <= bus.wdata;
               A_NR14: begin
                  r_sq1_freq[10:8] <= bus.wdata[2:0];
                  r_sq1_len_en     <= bus.wdata[6];
                  r_sq1_trig       <= bus.wdata[7];
               end
               A_NR21: begin
                  r_nr21        <= bus.wdata;
                  r_sq2_len_stb <= 1'b1;
               end
               A_NR22: r_nr22 <= bus.wdata;
               A_NR23: r_sq2_freq[7:0] <= bus.wdata;
               A_NR24: begin
                  r_sq2_freq[10:8] <= bus.wdata[2:0];
                  r_sq2_len_en     <= bus.wdata[6];
                  r_sq2_trig       <= bus.wdata[7];
               end
               A_NR50: begin
                  r_vol_left  <= bus.wdata[6:4];
                  r_vol_right <= bus.wdata[2:0];
               end
               A_NR51: r_pan <= bus.wdata;
               default: ;
            endcase
         end
      end
   end

   assign sq1_swpPd     = r_nr10[6:4];
   assign sq1_negate    = r_nr10[3];
   assign sq1_shift     = r_nr10[2:0];
   assign sq1_duty      = r_nr11[7:6];
   assign sq1_lenLoad   = r_nr11[5:0];
   assign sq1_lenStrobe = r_sq1_len_stb;
   assign sq1_startVol  = r_nr12[7:4];
   assign sq1_envAdd    = r_nr12[3];
   assign sq1_period    = r_nr12[2:0];
   assign sq1_freq      = r_sq1_freq;
   assign sq1_lenEnable = r_sq1_len_en;
   assign sq1_trigger   = r_sq1_trig;
   assign sq2_duty      = r_nr21[7:6];
   assign sq2_lenLoad   = r_nr21[5:0];
   assign sq2_lenStrobe = r_sq2_len_stb;
   assign sq2_startVol  = r_nr22[7:4];
   assign sq2_envAdd    = r_nr22[3];
   assign sq2_period    = r_nr22[2:0];
   assign sq2_freq      = r_sq2_freq;
   assign sq2_lenEnable = r_sq2_len_en;
   assign sq2_trigger   = r_sq2_trig;
   assign vol_left      = r_vol_left;
   assign vol_right     = r_vol_right;
   assign pan           = r_pan;
   assign power         = r_power;

`ifdef APU_READBACK_EN
   logic [1:0] r_vin;
   logic [7:0] r_rdata;
   logic       r_rvalid;
   logic [7:0] w_rd_data;

   // NR50 Vin bits exist only for read-back; cleared with the rest on power-off
   always_ff @(posedge clk) begin
      if (reset || w_pwr_off) begin
         r_vin <= '0;
      end else if (w_wr_lo && (bus.addr == A_NR50)) begin
         r_vin <= {bus.wdata[7], bus.wdata[3]};
      end
   end

   // Read mux: stored bits OR'ed with the write-only/unused-bit mask
   always_comb begin
      w_rd_data = 8'hFF;
      case (bus.addr)
         A_NR10:  w_rd_data = {1'b1, r_nr10};
         A_NR11:  w_rd_data = {r_nr11[7:6], 6'h3F};
         A_NR12:  w_rd_data = r_nr12;
         A_NR13:  w_rd_data = 8'hFF;
         A_NR14:  w_rd_data = {1'b1, r_sq1_len_en, 6'h3F};
         A_NR21:  w_rd_data = {r_nr21[7:6], 6'h3F};
         A_NR22:  w_rd_data = r_nr22;
         A_NR23:  w_rd_data = 8'hFF;
         A_NR24:  w_rd_data = {1'b1, r_sq2_len_en, 6'h3F};
         A_NR50:  w_rd_data = {r_vin[1], r_vol_left, r_vin[0], r_vol_right};
         A_NR51:  w_rd_data = r_pan;
         A_NR52:  w_rd_data = {r_power, 3'b111, bus.ch_on};
         default: w_rd_data = 8'hFF;
      endcase
   end

   // Registered read response; pre-write state is returned on a same-cycle write
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rdata  <= '0;
         r_rvalid <= 1'b0;
      end else begin
         r_rvalid <= bus.rd_en;
         if (bus.rd_en) begin
            r_rdata <= w_rd_data;
         end
      end
   end

   assign bus.rdata  = r_rdata;
   assign bus.rvalid = r_rvalid;
`else
   assign bus.rdata  = 8'h00;
   assign bus.rvalid = 1'b0;
`endif

endmodule

// File: tb/tb_apu_reg_file.sv
// Testbench for apu_reg_file: directed test-plan steps followed by random bus
// traffic, every cycle compared against a byte-image model of the register map.
module tb_apu_reg_file;

   logic        clk;
   logic        reset;
   logic [2:0]  sq1_swpPd;
   logic        sq1_negate;
   logic [2:0]  sq1_shift;
   logic [1:0]  sq1_duty, sq2_duty;
   logic [5:0]  sq1_lenLoad, sq2_lenLoad;
   logic        sq1_lenStrobe, sq2_lenStrobe;
   logic [3:0]  sq1_startVol, sq2_startVol;
   logic        sq1_envAdd, sq2_envAdd;
   logic [2:0]  sq1_period, sq2_period;
   logic [10:0] sq1_freq, sq2_freq;
   logic        sq1_lenEnable, sq2_lenEnable;
   logic        sq1_trigger, sq2_trigger;
   logic [2:0]  vol_left, vol_right;
   logic [7:0]  pan;
   logic        power;

   apu_reg_file_if bus ();

   apu_reg_file dut (
      .clk           (clk),
      .reset         (reset),
      .bus           (bus),
      .sq1_swpPd     (sq1_swpPd),
      .sq1_negate    (sq1_negate),
      .sq1_shift     (sq1_shift),
      .sq1_duty      (sq1_duty),
      .sq2_duty      (sq2_duty),
      .sq1_lenLoad   (sq1_lenLoad),
      .sq2_lenLoad   (sq2_lenLoad),
      .sq1_lenStrobe (sq1_lenStrobe),
      .sq2_lenStrobe (sq2_lenStrobe),
      .sq1_startVol  (sq1_startVol),
      .sq2_startVol  (sq2_startVol),
      .sq1_envAdd    (sq1_envAdd),
      .sq2_envAdd    (sq2_envAdd),
      .sq1_period    (sq1_period),
      .sq2_period    (sq2_period),
      .sq1_freq      (sq1_freq),
      .sq2_freq      (sq2_freq),
      .sq1_lenEnable (sq1_lenEnable),
      .sq2_lenEnable (sq2_lenEnable),
      .sq1_trigger   (sq1_trigger),
      .sq2_trigger   (sq2_trigger),
      .vol_left      (vol_left),
      .vol_right     (vol_right),
      .pan           (pan),
      .power         (power)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: one byte image per register address plus power and strobes
   logic [7:0] m_reg [256];
   logic       m_power;
   logic       m_trig1, m_trig2, m_len1, m_len2;
   logic [7:0] m_rdata;
   logic       m_rvalid;

   function automatic bit is_mapped(input logic [7:0] a);
      return (a >= 8'h10 && a <= 8'h14) || (a >= 8'h16 && a <= 8'h19) ||
             (a >= 8'h24 && a <= 8'h26);
   endfunction

   function automatic logic [7:0] rd_mask(input logic [7:0] a);
      case (a)
         8'h10:        return 8'h80;
         8'h11, 8'h16: return 8'h3F;
         8'h12, 8'h17: return 8'h00;
         8'h13, 8'h18: return 8'hFF;
         8'h14, 8'h19: return 8'hBF;
         8'h24, 8'h25: return 8'h00;
         default:      return 8'hFF;
      endcase
   endfunction

   function automatic logic [7:0] model_read(input logic [7:0] a, input logic [3:0] ch);
      if (a == 8'h26)     return {m_power, 3'b111, ch};
      else if (is_mapped(a)) return m_reg[a] | rd_mask(a);
      else                return 8'hFF;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 256; i++) m_reg[i] = 8'h00;
      m_power  = 1'b1;
      m_trig1  = 1'b0;
      m_trig2  = 1'b0;
      m_len1   = 1'b0;
      m_len2   = 1'b0;
      m_rdata  = 8'h00;
      m_rvalid = 1'b0;
   endtask

   task automatic model_edge(input logic rst, input logic w, input logic r,
                             input logic [7:0] a, input logic [7:0] d, input logic [3:0] ch);
      if (rst) begin
         model_reset();
         return;
      end
      m_trig1 = 1'b0;
      m_trig2 = 1'b0;
      m_len1  = 1'b0;
      m_len2  = 1'b0;
`ifdef APU_READBACK_EN
      m_rvalid = r;
      if (r) m_rdata = model_read(a, ch);
`else
      m_rvalid = 1'b0;
      m_rdata  = 8'h00;
`endif
      if (w) begin
         if (a == 8'h26) begin
            if (!d[7]) begin
               for (int i = 8'h10; i <= 8'h25; i++) m_reg[i] = 8'h00;
               m_power = 1'b0;
            end else begin
               m_power = 1'b1;
            end
         end else if (m_power && is_mapped(a)) begin
            m_reg[a] = d;
            if (a == 8'h11) m_len1 = 1'b1;
            if (a == 8'h16) m_len2 = 1'b1;
            if (a == 8'h14 && d[7]) m_trig1 = 1'b1;
            if (a == 8'h19 && d[7]) m_trig2 = 1'b1;
         end
      end
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
   endtask

   task automatic check_all();
      chk("sq1_swpPd",     16'(sq1_swpPd),     16'(m_reg[8'h10][6:4]));
      chk("sq1_negate",    16'(sq1_negate),    16'(m_reg[8'h10][3]));
      chk("sq1_shift",     16'(sq1_shift),     16'(m_reg[8'h10][2:0]));
      chk("sq1_duty",      16'(sq1_duty),      16'(m_reg[8'h11][7:6]));
      chk("sq1_lenLoad",   16'(sq1_lenLoad),   16'(m_reg[8'h11][5:0]));
      chk("sq1_lenStrobe", 16'(sq1_lenStrobe), 16'(m_len1));
      chk("sq1_startVol",  16'(sq1_startVol),  16'(m_reg[8'h12][7:4]));
      chk("sq1_envAdd",    16'(sq1_envAdd),    16'(m_reg[8'h12][3]));
      chk("sq1_period",    16'(sq1_period),    16'(m_reg[8'h12][2:0]));
      chk("sq1_freq",      16'(sq1_freq),      16'({m_reg[8'h14][2:0], m_reg[8'h13]}));
      chk("sq1_lenEnable", 16'(sq1_lenEnable), 16'(m_reg[8'h14][6]));
      chk("sq1_trigger",   16'(sq1_trigger),   16'(m_trig1));
      chk("sq2_duty",      16'(sq2_duty),      16'(m_reg[8'h16][7:6]));
      chk("sq2_lenLoad",   16'(sq2_lenLoad),   16'(m_reg[8'h16][5:0]));
      chk("sq2_lenStrobe", 16'(sq2_lenStrobe), 16'(m_len2));
      chk("sq2_startVol",  16'(sq2_startVol),  16'(m_reg[8'h17][7:4]));
      chk("sq2_envAdd",    16'(sq2_envAdd),    16'(m_reg[8'h17][3]));
      chk("sq2_period",    16'(sq2_period),    16'(m_reg[8'h17][2:0]));
      chk("sq2_freq",      16'(sq2_freq),      16'({m_reg[8'h19][2:0], m_reg[8'h18]}));
      chk("sq2_lenEnable", 16'(sq2_lenEnable), 16'(m_reg[8'h19][6]));
      chk("sq2_trigger",   16'(sq2_trigger),   16'(m_trig2));
      chk("vol_left",      16'(vol_left),      16'(m_reg[8'h24][6:4]));
      chk("vol_right",     16'(vol_right),     16'(m_reg[8'h24][2:0]));
      chk("pan",           16'(pan),           16'(m_reg[8'h25]));
      chk("power",         16'(power),         16'(m_power));
      chk("rdata",         16'(bus.rdata),     16'(m_rdata));
      chk("rvalid",        16'(bus.rvalid),    16'(m_rvalid));
   endtask

   // One clock: drive inputs, advance the model at the edge, compare just after it
   task automatic cycle(input logic rst, input logic w, input logic r,
                        input logic [7:0] a, input logic [7:0] d, input logic [3:0] ch);
      reset       = rst;
      bus.wr_en   = w;
      bus.rd_en   = r;
      bus.addr    = a;
      bus.wdata   = d;
      bus.ch_on   = ch;
      @(posedge clk);
      model_edge(rst, w, r, a, d, ch);
      #1;
      check_all();
   endtask

   task automatic wr(input logic [7:0] a, input logic [7:0] d);
      cycle(1'b0, 1'b1, 1'b0, a, d, 4'h0);
   endtask

   task automatic rd(input logic [7:0] a, input logic [3:0] ch);
      cycle(1'b0, 1'b0, 1'b1, a, 8'h00, ch);
   endtask

   task automatic idle();
      cycle(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 4'h0);
   endtask

   initial begin
      logic [7:0] ra, rdv;
      logic       rw, rr, rst;
      reset     = 1'b1;
      bus.wr_en = 1'b0;
      bus.rd_en = 1'b0;
      bus.addr  = 8'h00;
      bus.wdata = 8'h00;
      bus.ch_on = 4'h0;
      model_reset();

      // Reset state
      cycle(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 4'h0);
      cycle(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 4'h0);
      chk("reset_power", 16'(power), 16'h1);
      idle();

      // NR12 decode
      wr(8'h12, 8'hF3);
      chk("plan_startVol", 16'(sq1_startVol), 16'hF);
      chk("plan_period",   16'(sq1_period),   16'h3);

      // NR13/NR14 frequency bytes and trigger pulse
      wr(8'h13, 8'h6B);
      wr(8'h14, 8'hC7);
      chk("plan_trig_hi", 16'(sq1_trigger), 16'h1);
      chk("plan_freq",    16'(sq1_freq),    16'h76B);
      idle();
      chk("plan_trig_lo", 16'(sq1_trigger), 16'h0);
      rd(8'h14, 4'h0);
`ifdef APU_READBACK_EN
      chk("plan_rd_nr14", 16'(bus.rdata), 16'hFF);
`endif
      idle();

      // NR21 length load strobe and masked read
      wr(8'h16, 8'h9A);
      chk("plan_lenstb", 16'(sq2_lenStrobe), 16'h1);
      chk("plan_lenld",  16'(sq2_lenLoad),   16'h1A);
      rd(8'h16, 4'h0);
`ifdef APU_READBACK_EN
      chk("plan_rd_nr21", 16'(bus.rdata), 16'hBF);
`endif

      // Mixer writes, power-off clear, writes ignored while off
      wr(8'h24, 8'h75);
      wr(8'h25, 8'hF3);
      wr(8'h26, 8'h00);
      chk("plan_pwr_off", 16'(power), 16'h0);
      chk("plan_pan_clr", 16'(pan),   16'h0);
      wr(8'h25, 8'hFF);
      chk("plan_pan_ign", 16'(pan),   16'h0);
      rd(8'h26, 4'b0101);
`ifdef APU_READBACK_EN
      chk("plan_rd_nr52", 16'(bus.rdata), 16'h75);
`endif
      wr(8'h26, 8'h80);

      // Unmapped reads and same-cycle write/read ordering
      rd(8'h15, 4'h0);
      rd(8'h30, 4'h0);
      cycle(1'b0, 1'b1, 1'b1, 8'h17, 8'h44, 4'h0);
      rd(8'h17, 4'h0);
`ifdef APU_READBACK_EN
      chk("plan_rd_nr22", 16'(bus.rdata), 16'h44);
`endif
      idle();
      chk("plan_rvalid_lo", 16'(bus.rvalid), 16'h0);

      // Back-to-back triggers, then reset cancels a pending strobe
      wr(8'h19, 8'h80);
      wr(8'h19, 8'h81);
      chk("plan_b2b_trig", 16'(sq2_trigger), 16'h1);
      wr(8'h14, 8'h80);
      cycle(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 4'h0);
      chk("plan_rst_trig", 16'(sq1_trigger), 16'h0);
      idle();

      // Random traffic
      for (int i = 0; i < 800; i++) begin
         ra  = 8'($urandom_range(8'h0E, 8'h2A));
         rdv = 8'($urandom);
         if (ra == 8'h26 && ($urandom_range(0, 3) != 0)) rdv[7] = 1'b1;
         rw  = 1'($urandom_range(0, 3) != 0);
         rr  = 1'($urandom_range(0, 1));
         rst = 1'($urandom_range(0, 99) == 0);
         cycle(rst, rw, rr, ra, rdv, 4'($urandom));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
